set_job_scheduler: RTL and testbench
====================================

SET_JOB_SCHEDULER -- requirements
Module: set_job_scheduler

Interface
REQ-001 SHALL have ports: clk  in  1  single clock, all logic on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: req_valid[1:0]  in  2  per-requester job offer.
REQ-004 SHALL have ports: req_ready[1:0]  out  2  per-requester accept; one-hot or zero.
REQ-005 SHALL have ports: req_central0/1  in  24, req_radius0/1  in  12, req_mode0/1  in  2  job operands per requester.
REQ-006 SHALL have ports: eng_en  out  1, eng_central  out  24, eng_radius  out  12, eng_mode  out  2  SET engine launch.
REQ-007 SHALL have ports: eng_busy  in  1, eng_valid  in  1, eng_candidate  in  8  SET engine status and result.
REQ-008 SHALL have ports: rsp_valid  out  1, rsp_ready  in  1, rsp_id  out  1, rsp_candidate  out  8, rsp_err  out  1  result return.
REQ-009 SHALL have parameter: TIMEOUT, default 80, WAIT-state cycle limit before abort.

Function
REQ-010 SHALL implement FSM states IDLE, LAUNCH, WAIT, HOLD.
REQ-011 IDLE: if any req_valid, SHALL grant one requester, assert its req_ready that same cycle (combinational), latch its operands and id, go to LAUNCH.
REQ-012 Arbitration SHALL be round-robin: when both valid, grant the one not granted last; with one valid, grant it regardless of pointer.
REQ-013 Pointer SHALL update only on a grant; after reset req0 has priority.
REQ-014 LAUNCH: eng_en SHALL be 1 for exactly one cycle with latched operands on eng_central/radius/mode; next state WAIT.
REQ-015 eng_central/radius/mode SHALL hold latched values from LAUNCH until the next grant.
REQ-016 WAIT: on eng_valid=1, SHALL capture eng_candidate into rsp_candidate, rsp_err=0, go to HOLD.
REQ-017 WAIT: an 8-bit cycle counter SHALL reset on entry; if it reaches TIMEOUT without eng_valid, SHALL set rsp_candidate=0, rsp_err=1, go to HOLD.
REQ-018 HOLD: rsp_valid=1 with rsp_id = granted requester; on rsp_ready=1, go to IDLE next cycle.
REQ-019 rsp_valid, rsp_id, rsp_candidate, rsp_err SHALL remain stable while rsp_valid=1 and rsp_ready=0.
REQ-020 req_ready SHALL be 0 in LAUNCH, WAIT, HOLD; no job accepted until the response is consumed (one job in flight).
REQ-021 eng_valid outside WAIT SHALL be ignored; eng_busy SHALL be informational only.
REQ-022 req_valid deasserting without req_ready SHALL not alter state or pointer.

Reset
REQ-023 On rst=1: state IDLE, rr pointer favours req0, eng_en=0, rsp_valid=0, rsp_err=0, rsp_candidate=0, rsp_id=0, req_ready=0, counter=0, latched operands=0.
REQ-024 rst mid-job (any state) SHALL abandon the job; no response SHALL be produced for it.
REQ-025 rst SHALL take priority over every other input in the same cycle.

Structure
REQ-026 A shared package SHALL hold the state encoding (2 bits) and the default TIMEOUT constant.
REQ-027 A sub-module rr_arbiter2 SHALL contain the two-way round-robin grant logic and pointer.
REQ-028 All outputs except req_ready SHALL be registered.

Verification
REQ-029 Single job: req0 central=24'h440000, radius=12'h200, mode=0; engine model returns 13 -> one eng_en pulse, rsp_valid with rsp_id=0, rsp_candidate=13, rsp_err=0.
REQ-030 Contention: req0 and req1 valid continuously, rsp_ready=1 -> grants alternate 0,1,0,1 across four jobs, never both req_ready high.
REQ-031 Backpressure: rsp_ready=0 for 10 cycles in HOLD -> rsp fields stable, req_ready stays 0, no eng_en pulse.
REQ-032 Timeout: engine model never asserts eng_valid -> after 80 WAIT cycles rsp_valid=1, rsp_err=1, rsp_candidate=0.
REQ-033 Reset mid-WAIT: rst asserted one cycle during WAIT -> rsp_valid stays 0, next job granted to req0 first.
REQ-034 Stray eng_valid pulse in IDLE -> no response generated, state remains IDLE.

Source files
------------

// File: rtl/set_job_scheduler_pkg.sv
// Shared types and constants for the SET job scheduler: state encoding, job operand bundle, timeout default.
package set_job_scheduler_pkg;

    localparam int CENTRAL_W       = 24;
    localparam int RADIUS_W        = 12;
    localparam int MODE_W          = 2;
    localparam int CAND_W          = 8;
    localparam int CNT_W           = 8;
    localparam int TIMEOUT_DEFAULT = 80;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_HOLD   = 2'd3
    } state_e;

    typedef struct packed {
        logic [CENTRAL_W-1:0] central;
        logic [RADIUS_W-1:0]  radius;
        logic [MODE_W-1:0]    mode;
    } job_t;

endpackage

// File: rtl/set_job_scheduler_if.sv
// Requester, engine and response signals of the scheduler; slave is the scheduler side, master the environment.
interface set_job_scheduler_if;
    import set_job_scheduler_pkg::*;

    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [CENTRAL_W-1:0] req_central0;
    logic [CENTRAL_W-1:0] req_central1;
    logic [RADIUS_W-1:0]  req_radius0;
    logic [RADIUS_W-1:0]  req_radius1;
    logic [MODE_W-1:0]    req_mode0;
    logic [MODE_W-1:0]    req_mode1;

    logic                 eng_en;
    logic [CENTRAL_W-1:0] eng_central;
    logic [RADIUS_W-1:0]  eng_radius;
    logic [MODE_W-1:0]    eng_mode;
    logic                 eng_busy;
    logic                 eng_valid;
    logic [CAND_W-1:0]    eng_candidate;

    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_id;
    logic [CAND_W-1:0]    rsp_candidate;
    logic                 rsp_err;

    modport slave (
        input  req_valid, req_central0, req_central1, req_radius0, req_radius1,
               req_mode0, req_mode1, eng_busy, eng_valid, eng_candidate, rsp_ready,
        output req_ready, eng_en, eng_central, eng_radius, eng_mode,
               rsp_valid, rsp_id, rsp_candidate, rsp_err
    );

    modport master (
        output req_valid, req_central0, req_central1, req_radius0, req_radius1,
               req_mode0, req_mode1, eng_busy, eng_valid, eng_candidate, rsp_ready,
        input  req_ready, eng_en, eng_central, eng_radius, eng_mode,
               rsp_valid, rsp_id, rsp_candidate, rsp_err
    );

endinterface

// File: rtl/set_job_scheduler_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational grant, pointer remembers the last winner.
// Grants only while en_i is high; pointer moves only on an actual grant.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o,
    output logic       gnt_id_o
);

    logic last_q, last_d;

    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        if (en_i) begin
            // On contention the requester that did not win last time goes first
            if (req_i == 2'b11) begin
                gnt_o = last_q ? 2'b01 : 2'b10;
            end else begin
                gnt_o = req_i;
            end
            if (|req_i) begin
                last_d = gnt_o[1];
            end
        end
    end

    assign gnt_id_o = gnt_o[1];

    // Reset value 1 makes req0 the favoured requester
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/set_job_scheduler.sv
// Accepts one job at a time from two requesters, launches the SET engine, returns its result or a timeout error.
// Grant is same-cycle in IDLE; eng_en one cycle later; response held until rsp_ready, blocking new jobs meanwhile.
module set_job_scheduler
    import set_job_scheduler_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    set_job_scheduler_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    job_t              job_q, job_d, job0, job1;
    logic              id_q, id_d;
    logic              eng_en_q, eng_en_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [CAND_W-1:0] cand_q, cand_d;
    logic              err_q, err_d;
    logic [1:0]        gnt;
    logic              gnt_id;
    logic              timeout;

    assign job0    = '{central: bus.req_central0, radius: bus.req_radius0, mode: bus.req_mode0};
    assign job1    = '{central: bus.req_central1, radius: bus.req_radius1, mode: bus.req_mode1};
    assign timeout = (cnt_q == CNT_LAST);

    rr_arbiter2 u_arb (
        .clk      (clk),
        .rst      (rst),
        .en_i     ((state_q == ST_IDLE) && !rst),
        .req_i    (bus.req_valid),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            job_q       <= '0;
            id_q        <= 1'b0;
            eng_en_q    <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            cand_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            job_q       <= job_d;
            id_q        <= id_d;
            eng_en_q    <= eng_en_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            cand_q      <= cand_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (|gnt) state_d = ST_LAUNCH;
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT:   if (bus.eng_valid || timeout) state_d = ST_HOLD;
            ST_HOLD:   if (bus.rsp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        job_d       = job_q;
        id_d        = id_q;
        eng_en_d    = 1'b0;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        cand_d      = cand_q;
        err_d       = err_q;
        unique case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    job_d    = gnt_id ? job1 : job0;
                    id_d     = gnt_id;
                    eng_en_d = 1'b1;
                end
            end
            ST_LAUNCH: cnt_d = '0;
            ST_WAIT: begin
                // A real result wins over a timeout landing in the same cycle
                if (bus.eng_valid) begin
                    rsp_valid_d = 1'b1;
                    cand_d      = bus.eng_candidate;
                    err_d       = 1'b0;
                end else if (timeout) begin
                    rsp_valid_d = 1'b1;
                    cand_d      = '0;
                    err_d       = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HOLD: if (bus.rsp_ready) rsp_valid_d = 1'b0;
            default: ;
        endcase
    end

    assign bus.req_ready     = gnt;
    assign bus.eng_en        = eng_en_q;
    assign bus.eng_central   = job_q.central;
    assign bus.eng_radius    = job_q.radius;
    assign bus.eng_mode      = job_q.mode;
    assign bus.rsp_valid     = rsp_valid_q;
    assign bus.rsp_id        = id_q;
    assign bus.rsp_candidate = cand_q;
    assign bus.rsp_err       = err_q;

endmodule

// File: tb/tb_set_job_scheduler.sv
// Directed bench for set_job_scheduler: bench drives requesters and plays the engine; all checks at negedge.
`timescale 1ns/1ps
module tb_set_job_scheduler;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    set_job_scheduler_if bus();

    set_job_scheduler #(.TIMEOUT(80)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks  = 0;
    int n_fail    = 0;
    int en_pulses = 0;
    int both_hi   = 0;

    always @(posedge clk) begin
        if (bus.eng_en === 1'b1) en_pulses++;
        if (bus.req_ready === 2'b11) both_hi++;
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = 2'b11;
        bus.req_central0 = 24'h123456;
        step(); step();
        #1;
        n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL reset_req_ready got=%b want=00", bus.req_ready); end
        n_checks++; if (bus.eng_en !== 1'b0) begin n_fail++; $display("FAIL reset_eng_en got=%b want=0", bus.eng_en); end
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b want=0", bus.rsp_valid); end
        n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got=%b want=0", bus.rsp_err); end
        n_checks++; if (bus.rsp_candidate !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_candidate got=%h want=00", bus.rsp_candidate); end
        n_checks++; if (bus.rsp_id !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_id got=%b want=0", bus.rsp_id); end
        n_checks++; if (bus.eng_central !== 24'h0) begin n_fail++; $display("FAIL reset_eng_central got=%h want=0", bus.eng_central); end
        n_checks++; if (bus.eng_radius !== 12'h0) begin n_fail++; $display("FAIL reset_eng_radius got=%h want=0", bus.eng_radius); end
        n_checks++; if (bus.eng_mode !== 2'h0) begin n_fail++; $display("FAIL reset_eng_mode got=%h want=0", bus.eng_mode); end
        bus.req_valid = 2'b00;
        rst = 1'b0;
        step();
    endtask

    task automatic test_single_job();
        int p0;
        p0 = en_pulses;
        bus.req_central0 = 24'h440000;
        bus.req_radius0  = 12'h200;
        bus.req_mode0    = 2'd0;
        bus.req_valid    = 2'b01;
        #1;
        n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL single_grant got=%b want=01", bus.req_ready); end
        step();
        bus.req_valid = 2'b00;
        n_checks++; if (bus.eng_en !== 1'b1) begin n_fail++; $display("FAIL single_eng_en got=%b want=1", bus.eng_en); end
        n_checks++; if (bus.eng_central !== 24'h440000) begin n_fail++; $display("FAIL single_eng_central got=%h want=440000", bus.eng_central); end
        n_checks++; if (bus.eng_radius !== 12'h200) begin n_fail++; $display("FAIL single_eng_radius got=%h want=200", bus.eng_radius); end
        n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL single_launch_ready got=%b want=00", bus.req_ready); end
        step();
        n_checks++; if (bus.eng_en !== 1'b0) begin n_fail++; $display("FAIL single_eng_en_drop got=%b want=0", bus.eng_en); end
        bus.eng_valid = 1'b1;
        bus.eng_candidate = 8'd13;
        step();
        bus.eng_valid = 1'b0;
        n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL single_rsp_valid got=%b want=1", bus.rsp_valid); end
        n_checks++; if (bus.rsp_id !== 1'b0) begin n_fail++; $display("FAIL single_rsp_id got=%b want=0", bus.rsp_id); end
        n_checks++; if (bus.rsp_candidate !== 8'd13) begin n_fail++; $display("FAIL single_rsp_candidate got=%0d want=13", bus.rsp_candidate); end
        n_checks++; if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL single_rsp_err got=%b want=0", bus.rsp_err); end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL single_rsp_consumed got=%b want=0", bus.rsp_valid); end
        n_checks++; if (bus.eng_central !== 24'h440000) begin n_fail++; $display("FAIL single_operand_hold got=%h want=440000", bus.eng_central); end
        n_checks++; if (en_pulses - p0 !== 1) begin n_fail++; $display("FAIL single_pulse_count got=%0d want=1", en_pulses - p0); end
    endtask

    task automatic test_contention();
        logic [1:0] exp_gnt;
        logic       exp_id;
        logic [23:0] exp_central;
        int k;
        rst = 1'b1;
        step();
        rst = 1'b0;
        both_hi = 0;
        bus.req_central0 = 24'h111111; bus.req_radius0 = 12'h011; bus.req_mode0 = 2'd1;
        bus.req_central1 = 24'h222222; bus.req_radius1 = 12'h022; bus.req_mode1 = 2'd2;
        bus.rsp_ready = 1'b1;
        bus.req_valid = 2'b11;
        for (k = 0; k < 4; k++) begin
            exp_id      = k[0];
            exp_gnt     = exp_id ? 2'b10 : 2'b01;
            exp_central = exp_id ? 24'h222222 : 24'h111111;
            #1;
            n_checks++; if (bus.req_ready !== exp_gnt) begin n_fail++; $display("FAIL contention_grant%0d got=%b want=%b", k, bus.req_ready, exp_gnt); end
            step();
            n_checks++; if (bus.eng_central !== exp_central) begin n_fail++; $display("FAIL contention_central%0d got=%h want=%h", k, bus.eng_central, exp_central); end
            step();
            bus.eng_valid = 1'b1;
            bus.eng_candidate = 8'(k + 1);
            step();
            bus.eng_valid = 1'b0;
            n_checks++; if (bus.rsp_id !== exp_id) begin n_fail++; $display("FAIL contention_rsp_id%0d got=%b want=%b", k, bus.rsp_id, exp_id); end
            n_checks++; if (bus.rsp_candidate !== 8'(k + 1)) begin n_fail++; $display("FAIL contention_cand%0d got=%0d want=%0d", k, bus.rsp_candidate, k + 1); end
            step();
        end
        n_checks++; if (both_hi !== 0) begin n_fail++; $display("FAIL contention_both_ready got=%0d cycles want=0", both_hi); end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        int p0;
        bus.req_central1 = 24'hABCDEF; bus.req_radius1 = 12'h0FF; bus.req_mode1 = 2'd3;
        bus.req_valid = 2'b10;
        #1;
        n_checks++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL bp_grant got=%b want=10", bus.req_ready); end
        step();
        bus.req_valid = 2'b11;
        step();
        bus.eng_valid = 1'b1;
        bus.eng_candidate = 8'h5A;
        step();
        bus.eng_valid = 1'b0;
        p0 = en_pulses;
        for (int i = 0; i < 10; i++) begin
            n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL bp_rsp_valid%0d got=%b want=1", i, bus.rsp_valid); end
            n_checks++; if (bus.rsp_id !== 1'b1 || bus.rsp_candidate !== 8'h5A || bus.rsp_err !== 1'b0) begin
                n_fail++; $display("FAIL bp_rsp_fields%0d got=id%b/%h/err%b want=id1/5a/err0", i, bus.rsp_id, bus.rsp_candidate, bus.rsp_err);
            end
            n_checks++; if (bus.req_ready !== 2'b00) begin n_fail++; $display("FAIL bp_req_ready%0d got=%b want=00", i, bus.req_ready); end
            step();
        end
        n_checks++; if (en_pulses - p0 !== 0) begin n_fail++; $display("FAIL bp_no_launch got=%0d want=0", en_pulses - p0); end
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got=%b want=0", bus.rsp_valid); end
    endtask

    task automatic test_timeout();
        bit early;
        early = 1'b0;
        bus.req_central0 = 24'h440000; bus.req_radius0 = 12'h200; bus.req_mode0 = 2'd0;
        bus.req_valid = 2'b01;
        step();
        bus.req_valid = 2'b00;
        n_checks++; if (bus.eng_en !== 1'b1) begin n_fail++; $display("FAIL timeout_launch got=%b want=1", bus.eng_en); end
        for (int i = 1; i <= 80; i++) begin
            step();
            if (bus.rsp_valid !== 1'b0) early = 1'b1;
        end
        n_checks++; if (early) begin n_fail++; $display("FAIL timeout_early got=rsp_valid before 80 WAIT cycles want=none"); end
        step();
        n_checks++; if (bus.rsp_valid !== 1'b1) begin n_fail++; $display("FAIL timeout_rsp_valid got=%b want=1", bus.rsp_valid); end
        n_checks++; if (bus.rsp_err !== 1'b1) begin n_fail++; $display("FAIL timeout_rsp_err got=%b want=1", bus.rsp_err); end
        n_checks++; if (bus.rsp_candidate !== 8'h00) begin n_fail++; $display("FAIL timeout_rsp_cand got=%h want=00", bus.rsp_candidate); end
        n_checks++; if (bus.rsp_id !== 1'b0) begin n_fail++; $display("FAIL timeout_rsp_id got=%b want=0", bus.rsp_id); end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_wait();
        bit seen;
        seen = 1'b0;
        bus.req_valid = 2'b01;
        step();
        bus.req_valid = 2'b00;
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_checks++; if (bus.eng_central !== 24'h0) begin n_fail++; $display("FAIL midrst_operands got=%h want=0", bus.eng_central); end
        bus.eng_valid = 1'b1;
        bus.eng_candidate = 8'h99;
        step();
        bus.eng_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (bus.rsp_valid !== 1'b0) seen = 1'b1;
            step();
        end
        n_checks++; if (seen) begin n_fail++; $display("FAIL midrst_rsp got=rsp_valid seen want=none"); end
        bus.req_valid = 2'b11;
        #1;
        n_checks++; if (bus.req_ready !== 2'b01) begin n_fail++; $display("FAIL midrst_priority got=%b want=01", bus.req_ready); end
        step();
        bus.req_valid = 2'b00;
        step();
        bus.eng_valid = 1'b1;
        bus.eng_candidate = 8'h21;
        step();
        bus.eng_valid = 1'b0;
        n_checks++; if (bus.rsp_candidate !== 8'h21 || bus.rsp_id !== 1'b0) begin n_fail++; $display("FAIL midrst_job got=%h/id%b want=21/id0", bus.rsp_candidate, bus.rsp_id); end
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_stray_eng_valid();
        int p0;
        p0 = en_pulses;
        bus.eng_valid = 1'b1;
        bus.eng_candidate = 8'h77;
        step(); step();
        bus.eng_valid = 1'b0;
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stray_rsp_valid got=%b want=0", bus.rsp_valid); end
        n_checks++; if (bus.rsp_candidate !== 8'h21) begin n_fail++; $display("FAIL stray_rsp_cand got=%h want=21", bus.rsp_candidate); end
        bus.req_valid = 2'b10;
        #1;
        n_checks++; if (bus.req_ready !== 2'b10) begin n_fail++; $display("FAIL stray_still_idle got=%b want=10", bus.req_ready); end
        bus.req_valid = 2'b00;
        step(); step();
        n_checks++; if (en_pulses - p0 !== 0) begin n_fail++; $display("FAIL stray_withdraw_launch got=%0d want=0", en_pulses - p0); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_central0 = '0; bus.req_central1 = '0;
        bus.req_radius0 = '0;  bus.req_radius1 = '0;
        bus.req_mode0 = '0;    bus.req_mode1 = '0;
        bus.eng_busy = 1'b0;
        bus.eng_valid = 1'b0;
        bus.eng_candidate = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_single_job();
        test_contention();
        test_backpressure();
        test_timeout();
        test_reset_mid_wait();
        test_stray_eng_valid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
